// File: rtl/fifo_pkg.sv
// Shared types and constants for the byte-FIFO word reader.
package fifo_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        EMIT
    } rd_state_t;

    // Contiguous byte-valid mask covering the lowest n lanes.
    function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [WORD_BYTES-1:0] one;
        one = 1;
        return (one << n) - one;
    endfunction

endpackage

// File: rtl/fifo_word_out_reg.sv
// Output holding register with a valid/ready handshake.
module fifo_word_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last
);

    // A load always wins; otherwise the word stays put until it is accepted.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_reader.sv
// Pops bytes from a registered-output FIFO and packs them into 32-bit words.
module fifo_word_reader
    import fifo_pkg::*;
#(
    parameter int WORD_BYTES = fifo_pkg::WORD_BYTES,
    parameter int BYTE_W     = fifo_pkg::BYTE_W
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         fifo_empty,
    input  logic [BYTE_W-1:0]            fifo_dout,
    output logic                         fifo_rd,
    output logic [WORD_BYTES*BYTE_W-1:0] m_data,
    output logic [WORD_BYTES-1:0]        m_keep,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         busy
);

    localparam int WORD_W = WORD_BYTES * BYTE_W;
    localparam logic [CNT_W:0]   FILL_MAX  = (CNT_W + 1)'(WORD_BYTES);
    localparam logic [CNT_W:0]   FILL_LAST = (CNT_W + 1)'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(WORD_BYTES - 1);

    rd_state_t             state;
    rd_state_t             state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  pend;
    logic [WORD_W-1:0]     hold;
    logic [CNT_W:0]        fill;
    logic                  out_free;
    logic                  capture_last;
    logic                  emit_partial;
    logic [WORD_W-1:0]     full_word;
    logic [WORD_W-1:0]     lane_mask;
    logic [WORD_BYTES-1:0] partial_keep;
    logic                  load;
    logic [WORD_W-1:0]     load_data;
    logic [WORD_BYTES-1:0] load_keep;
    logic                  load_last;

    assign fill         = {1'b0, cnt} + {{CNT_W{1'b0}}, pend};
    assign out_free     = !m_valid || m_ready;
    assign capture_last = pend && (cnt == LANE_LAST);
    assign partial_keep = keep_mask(cnt);
    assign busy         = (state != IDLE) || pend || (cnt != '0);

    // Only pop when the byte has room and, for the final lane, the output can take the word.
    always_comb begin
        fifo_rd = 1'b0;
        if (state == RUN && en && !fifo_empty && fill < FILL_MAX) begin
            fifo_rd = (fill != FILL_LAST) || out_free;
        end
    end

    // Assemble the full word with the live byte in the top lane, and the zero-fill mask for partials.
    always_comb begin
        full_word = hold;
        full_word[(WORD_BYTES-1)*BYTE_W +: BYTE_W] = fifo_dout;
        lane_mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{partial_keep[i]}};
        end
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the output-register load request for full and flushed words.
    always_comb begin
        state_next   = state;
        emit_partial = 1'b0;
        load         = 1'b0;
        load_data    = '0;
        load_keep    = '0;
        load_last    = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = DRAIN;
                end else if (!en && !pend) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (!pend && out_free) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                emit_partial = (cnt != '0);
                state_next   = en ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (capture_last) begin
            load      = 1'b1;
            load_data = full_word;
            load_keep = '1;
        end else if (emit_partial) begin
            load      = 1'b1;
            load_data = hold & lane_mask;
            load_keep = partial_keep;
            load_last = 1'b1;
        end
    end

    // Capture the popped byte into its lane one cycle after the pop; cnt wraps after the last lane.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            cnt  <= '0;
            hold <= '0;
        end else begin
            pend <= fifo_rd;
            if (pend) begin
                hold[int'(cnt)*BYTE_W +: BYTE_W] <= fifo_dout;
                cnt <= cnt + 1'b1;
            end else if (emit_partial) begin
                cnt <= '0;
            end
        end
    end

    fifo_word_out_reg #(
        .DATA_W(WORD_W),
        .KEEP_W(WORD_BYTES)
    ) u_out_reg (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .load_keep(load_keep),
        .load_last(load_last),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench: behavioural byte FIFO, handshake monitor and byte-stream scoreboard.
module tb_fifo_word_reader;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Byte FIFO model: the initial block owns wr_ptr, the FIFO process owns rd_ptr.
    logic [7:0] fifo_mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr;

    // Scoreboard: every byte pushed, in order, waiting to appear in an output beat.
    logic [7:0] exp_bytes [$];

    // Monitor records, written only by the monitor process.
    logic [31:0] obs_data [0:63];
    logic [3:0]  obs_keep [0:63];
    logic        obs_last [0:63];
    int          obs_n   = 0;
    int          obs_rd  = 0;
    int          pop_n   = 0;
    int          pop_cyc [0:63];
    int          cyc     = 0;
    int          rd_viol = 0;

    fifo_word_reader dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Registered-output FIFO: data appears the cycle after an accepted pop.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 0;
            fifo_dout <= 8'h00;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Sample pops and handshakes mid-cycle, away from the active edge.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (fifo_rd) begin
                pop_cyc[pop_n % 64] <= cyc;
                pop_n <= pop_n + 1;
                if (fifo_empty) rd_viol <= rd_viol + 1;
            end
            if (m_valid && m_ready) begin
                obs_data[obs_n % 64] <= m_data;
                obs_keep[obs_n % 64] <= m_keep;
                obs_last[obs_n % 64] <= m_last;
                obs_n <= obs_n + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic en_v, input logic ready_v);
        en      = en_v;
        m_ready = ready_v;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
        exp_bytes.push_back(b);
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next beat must carry the next nbytes of the pushed stream, zero-filled above them.
    task automatic checkBeat(input string tag, input int nbytes, input logic exp_last);
        int          waited;
        logic [31:0] d;
        logic [3:0]  k;
        waited = 0;
        while (obs_n <= obs_rd && waited < 200) begin
            tick(1);
            waited++;
        end
        if (obs_n <= obs_rd) begin
            checkOutput({tag, "_timeout"}, 32'(obs_n - obs_rd), 32'd1);
            return;
        end
        d = '0;
        for (int i = 0; i < nbytes; i++) begin
            if (exp_bytes.size() > 0) d[8*i +: 8] = exp_bytes.pop_front();
        end
        k = 4'((1 << nbytes) - 1);
        checkOutput({tag, "_data"}, obs_data[obs_rd % 64], d);
        checkOutput({tag, "_keep"}, 32'(obs_keep[obs_rd % 64]), 32'(k));
        checkOutput({tag, "_last"}, 32'(obs_last[obs_rd % 64]), 32'(exp_last));
        obs_rd++;
    endtask

    initial begin
        int p0;
        int b0;
        rst_n   = 1'b1;
        en      = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        #2;
        rst_n  = 1'b0;
        wr_ptr = 0;
        #1;
        // Outputs while held in reset.
        checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_data",  m_data,       32'd0);
        checkOutput("rst_m_keep",  32'(m_keep),  32'd0);
        checkOutput("rst_m_last",  32'(m_last),  32'd0);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        tick(3);
        rst_n = 1'b1;

        // Single full word popped on four consecutive clocks.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        applyStimulus(1'b1, 1'b1);
        checkOutput("no_pop_in_idle", 32'(fifo_rd), 32'd0);
        p0 = pop_n;
        tick(12);
        checkOutput("word1_pops", 32'(pop_n - p0), 32'd4);
        checkOutput("word1_consecutive", 32'(pop_cyc[(p0 + 3) % 64] - pop_cyc[p0 % 64]), 32'd3);
        checkOutput("word1_value", obs_data[obs_rd % 64], 32'h44332211);
        checkBeat("word1", 4, 1'b0);
        checkOutput("word1_one_beat", 32'(obs_n - obs_rd), 32'd0);

        // Backpressure: the pop that would complete the second word waits for the handshake.
        applyStimulus(1'b1, 1'b0);
        p0 = pop_n;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        tick(20);
        checkOutput("bp_seven_pops", 32'(pop_n - p0), 32'd7);
        checkOutput("bp_valid_held", 32'(m_valid), 32'd1);
        checkOutput("bp_keep_held", 32'(m_keep), 32'hF);
        applyStimulus(1'b1, 1'b1);
        tick(10);
        checkOutput("bp_all_pops", 32'(pop_n - p0), 32'd8);
        checkBeat("bp_w0", 4, 1'b0);
        checkBeat("bp_w1", 4, 1'b0);

        // Random downstream readiness over three words.
        for (int i = 0; i < 12; i++) push(8'($urandom));
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 1'($urandom % 2));
            tick(1);
        end
        applyStimulus(1'b1, 1'b1);
        tick(10);
        for (int i = 0; i < 3; i++) checkBeat($sformatf("rnd_w%0d", i), 4, 1'b0);

        // Flush of three held bytes.
        push(8'hA1); push(8'hB2); push(8'hC3);
        tick(8);
        checkOutput("flush3_no_early_word", 32'(obs_n - obs_rd), 32'd0);
        pulseFlush();
        tick(4);
        checkOutput("flush3_value", obs_data[obs_rd % 64], 32'h00C3B2A1);
        checkBeat("flush3", 3, 1'b1);

        // Flush with nothing held produces no word and pops resume afterwards.
        tick(4);
        b0 = obs_n;
        pulseFlush();
        tick(6);
        checkOutput("flush_empty_no_word", 32'(obs_n - b0), 32'd0);
        p0 = pop_n;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        tick(2);
        checkOutput("flush_empty_resume", 32'(pop_n - p0), 32'd2);
        tick(8);
        checkBeat("after_flush", 4, 1'b0);

        // Long burst with enable dropped mid-way.
        for (int i = 0; i < 32; i++) push(8'($urandom));
        applyStimulus(1'b1, 1'b1);
        tick(10);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        p0 = pop_n;
        tick(6);
        checkOutput("en_low_no_pop", 32'(pop_n - p0), 32'd0);
        applyStimulus(1'b1, 1'b1);
        tick(60);
        for (int i = 0; i < 8; i++) checkBeat($sformatf("burst_w%0d", i), 4, 1'b0);
        checkOutput("burst_no_extra", 32'(obs_n - obs_rd), 32'd0);

        // Reset with two bytes held discards them asynchronously.
        push(8'($urandom)); push(8'($urandom));
        tick(6);
        checkOutput("held_busy", 32'(busy), 32'd1);
        #2;
        rst_n  = 1'b0;
        wr_ptr = 0;
        exp_bytes.delete();
        #1;
        checkOutput("async_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("async_m_valid", 32'(m_valid), 32'd0);
        checkOutput("async_m_data",  m_data,       32'd0);
        checkOutput("async_m_keep",  32'(m_keep),  32'd0);
        checkOutput("async_m_last",  32'(m_last),  32'd0);
        checkOutput("async_busy",    32'(busy),    32'd0);
        obs_rd = obs_n;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        tick(14);
        checkBeat("post_reset", 4, 1'b0);
        tick(4);
        checkOutput("post_reset_no_extra", 32'(obs_n - obs_rd), 32'd0);
        checkOutput("pop_when_empty", 32'(rd_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
